// File: rtl/slice_adder_sequencer.sv
// Multi-cycle adder controller: walks two WIDTH-bit operands through an external
// 3-bit slice adder, LSB slice first, and assembles the full-width sum and carry-out.
module slice_adder_sequencer #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [2:0]       add_a,
    output logic [2:0]       add_b,
    output logic             add_cin,
    input  logic [2:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int SLICES = WIDTH / 3;
    localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [IDXW-1:0]  idx_r;
    logic [WIDTH+2:0] sum_cat_s;
    logic             run_s;
    logic             done_s;

    // New slice sum enters at the top; after SLICES shifts slice 0 sits at the bottom.
    assign sum_cat_s = {add_sum, sum_sh_r};
    assign run_s     = (state_r == ST_RUN);
    assign done_s    = (state_r == ST_DONE);

    // Everything below decodes straight from registers, so no in_* signal reaches an output.
    assign add_a     = run_s  ? a_sh_r[2:0] : 3'd0;
    assign add_b     = run_s  ? b_sh_r[2:0] : 3'd0;
    assign add_cin   = run_s  ? carry_r     : 1'b0;
    assign out_valid = done_s;
    assign out_sum   = done_s ? sum_sh_r    : {WIDTH{1'b0}};
    assign out_cout  = done_s ? carry_r     : 1'b0;
    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept in IDLE, step through slices in RUN, hold result in DONE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, running carry and slice counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            idx_r    <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh_r   <= in_a;
                        b_sh_r   <= in_b;
                        sum_sh_r <= {WIDTH{1'b0}};
                        carry_r  <= in_cin;
                        idx_r    <= {IDXW{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= a_sh_r >> 3'd3;
                    b_sh_r   <= b_sh_r >> 3'd3;
                    sum_sh_r <= sum_cat_s[WIDTH+2:3];
                    carry_r  <= add_cout;
                    idx_r    <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
                end
                ST_DONE: begin
                    sum_sh_r <= sum_sh_r;
                    carry_r  <= carry_r;
                end
                default: begin
                    idx_r <= {IDXW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Scoreboard bench for slice_adder_sequencer (WIDTH=12) with an ideal 3-bit slice adder model.
module tb_slice_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        in_cin;
    logic [2:0]  add_a;
    logic [2:0]  add_b;
    logic        add_cin;
    logic [2:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic        out_cout;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [12:0] exp_q[$];

    slice_adder_sequencer #(.WIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Ideal 3-bit slice adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: every result handshake is compared against the oldest expectation
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {19'd0, out_cout, out_sum}, 32'hFFFF_FFFF);
            end else begin
                check("result", {19'd0, out_cout, out_sum}, {19'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Single accept; returns at the negedge right after the accepting edge
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic c, input bit push);
        logic [12:0] s;
        wait_ready();
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        s = {1'b0, a} + {1'b0, b} + {12'd0, c};
        if (push) exp_q.push_back(s);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Back-to-back with in_valid and out_ready held high; checks accept spacing
    task automatic burst(input int n, input bit rnd);
        int last = 0;
        logic [11:0] a, b;
        logic c;
        logic [12:0] s;
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                a = 12'($urandom_range(0, 4095));
                b = 12'($urandom_range(0, 4095));
                c = 1'($urandom_range(0, 1));
            end else begin
                a = 12'(i * 12'h3C7 + 12'hE01);
                b = 12'(12'hFFF - i * 12'h111);
                c = 1'(i % 2);
            end
            wait_ready();
            in_a = a; in_b = b; in_cin = c;
            s = {1'b0, a} + {1'b0, b} + {12'd0, c};
            exp_q.push_back(s);
            @(posedge clk);
            if (i > 0) check("accept_period", 32'(cyc - last), 32'd6);
            last = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] ea[4];
        logic [2:0] eb[4];
        logic       ec[4];
        int         cnt;
        bit         extra;
        ea = '{3'd5, 3'd4, 3'd6, 3'd2};
        eb = '{3'd3, 3'd4, 3'd2, 3'd0};
        ec = '{1'b1, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0; in_valid = 1'b0; in_a = 12'd0; in_b = 12'd0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out", {19'd0, out_cout, out_sum}, 32'd0);
        check("rst_add", {25'd0, add_a, add_b, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: wrap to zero with carry, 4-cycle latency
        send(12'hFFF, 12'h001, 1'b0, 1'b1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("latency", 32'(cnt), 32'd4);
        check("busy_done", {31'd0, busy}, 32'd1);
        wait_ready();

        // 2: slice sequence seen by the slice adder
        send(12'h5A5, 12'h0A3, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("add_a_%0d", k), {29'd0, add_a}, {29'd0, ea[k]});
            check($sformatf("add_b_%0d", k), {29'd0, add_b}, {29'd0, eb[k]});
            check($sformatf("add_cin_%0d", k), {31'd0, add_cin}, {31'd0, ec[k]});
            @(negedge clk);
        end
        check("done_add_zero", {25'd0, add_a, add_b, add_cin}, 32'd0);
        wait_ready();

        // 3: backpressure in DONE
        out_ready = 1'b0;
        send(12'h123, 12'h456, 1'b0, 1'b1);
        wait_valid();
        for (int k = 0; k < 3; k++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {19'd0, out_cout, out_sum}, 32'h0579);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("hs_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);

        // 4: in_valid during RUN is ignored
        send(12'h222, 12'h333, 1'b1, 1'b1);
        @(negedge clk);
        in_a = 12'h111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready();
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        check("no_second_result", {31'd0, extra}, 32'd0);

        // 5: reset in the middle of RUN
        send(12'h321, 12'h456, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_add", {25'd0, add_a, add_b, add_cin}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(12'h7FF, 12'h001, 1'b0, 1'b1);
        wait_valid();
        @(negedge clk);

        // 6: back-to-back directed, then random sweep
        burst(6, 1'b0);
        burst(1000, 1'b1);

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
